// File: rtl/block_transform_engine.sv
// Block transform engine: buffers one DEPTH-word block, applies a run-time selected
// element-wise transform, and streams the result out over a valid/ready handshake.
module block_transform_engine #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [3:0]        state_out
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LOAD = 4'd1,
        S_PROC = 4'd2,
        S_SAVE = 4'd3,
        S_DONE = 4'd4
    } state_e;

    state_e             state_q, state_d;
    logic               start_q;
    logic [1:0]         mode_q;
    logic [DATA_W-1:0]  bias_q;
    logic [DEPTH-1:0]   mask_q;
    logic [CNT_W-1:0]   cyc_q;
    logic               s1_valid_q;
    logic [IDX_W-1:0]   s1_idx_q;
    logic [DATA_W-1:0]  s1_data_q;
    logic [ADDR_W-1:0]  out_addr_q;

    logic [DATA_W-1:0]  in_buf  [DEPTH];
    logic [DATA_W-1:0]  out_buf [DEPTH];

    logic               start_edge;
    logic               in_addr_ok;
    logic               wr_en;
    logic               rd_en;
    logic               mask_full;
    logic               proc_last;
    logic               last_xfer;
    logic [DATA_W-1:0]  xform_d;

    assign start_edge = start & ~start_q;
    assign in_addr_ok = CNT_W'(in_addr) < CNT_W'(DEPTH);
    assign wr_en      = (state_q == S_LOAD) && in_valid && in_addr_ok;
    assign rd_en      = (state_q == S_PROC) && (cyc_q < CNT_W'(DEPTH));
    assign mask_full  = &mask_q;
    assign proc_last  = cyc_q == CNT_W'(DEPTH + 1);
    assign last_xfer  = (state_q == S_SAVE) && out_ready && (out_addr_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_edge) state_d = S_LOAD;
            S_LOAD:  if (mask_full)  state_d = S_PROC;
            S_PROC:  if (proc_last)  state_d = S_SAVE;
            S_SAVE:  if (last_xfer)  state_d = S_DONE;
            S_DONE:  if (!start_q)   state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        state_out = state_q;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_PROC: busy = 1'b1;
            S_SAVE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Control registers; the mask is cleared on the same edge that enters LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q    <= 1'b0;
            mode_q     <= '0;
            bias_q     <= '0;
            mask_q     <= '0;
            cyc_q      <= '0;
            s1_valid_q <= 1'b0;
            out_addr_q <= '0;
        end else begin
            start_q <= start;
            if ((state_q == S_IDLE) && start_edge) begin
                mode_q <= mode;
                bias_q <= bias;
                mask_q <= '0;
            end else if (wr_en) begin
                mask_q[in_addr[IDX_W-1:0]] <= 1'b1;
            end
            if (state_q == S_PROC) begin
                cyc_q <= cyc_q + 1'b1;
            end else begin
                cyc_q <= '0;
            end
            s1_valid_q <= rd_en;
            if ((state_q == S_SAVE) && out_ready) begin
                out_addr_q <= last_xfer ? '0 : out_addr_q + 1'b1;
            end
        end
    end

    always_comb begin
        xform_d = s1_data_q;
        case (mode_q)
            2'd0: xform_d = s1_data_q;
            2'd1: xform_d = ~s1_data_q;
            2'd2: xform_d = s1_data_q + bias_q;
            2'd3: xform_d = (s1_data_q >= bias_q) ? (s1_data_q - bias_q) : '0;
            default: ;
        endcase
    end

    // Storage is not reset: every word is rewritten before it can be observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            in_buf[in_addr[IDX_W-1:0]] <= in_data;
        end
        if (rd_en) begin
            s1_data_q <= in_buf[cyc_q[IDX_W-1:0]];
            s1_idx_q  <= cyc_q[IDX_W-1:0];
        end
        if (s1_valid_q) begin
            out_buf[s1_idx_q] <= xform_d;
        end
    end

    assign out_addr = out_addr_q;
    assign out_data = out_buf[out_addr_q[IDX_W-1:0]];

endmodule

// File: tb/tb_block_transform_engine.sv
// Randomised scoreboard bench for block_transform_engine against a plain arithmetic model.
module tb_block_transform_engine;
    localparam int DW = 32;
    localparam int DP = 64;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = '0;
    logic [DW-1:0] bias = '0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, busy, done;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic [3:0]    state_out;

    block_transform_engine #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bias(bias),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done), .state_out(state_out)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] blk [DP];
    int            errors = 0;
    int            checks = 0;
    int            beats = 0;
    int            proc_cyc = 0;
    int            rdy_mode = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] st_a;
    logic [DW-1:0] st_d;

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] xform(input logic [1:0] m, input logic [DW-1:0] b,
                                            input logic [DW-1:0] x);
        case (m)
            2'd0:    return x;
            2'd1:    return ~x;
            2'd2:    return x + b;
            default: return (x >= b) ? x - b : '0;
        endcase
    endfunction

    // Monitor: pops expected beats on every accepted transfer, checks stall stability.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (state_out == 4'd2) proc_cyc++;
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_addr", out_addr, st_a);
                chk("stall_data", out_data, st_d);
            end
            if (!out_valid) chk("idle_out_addr", out_addr, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", out_valid, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_addr", out_addr, e.a);
                    chk("beat_data", out_data, e.d);
                    beats++;
                end
            end
            prev_stall = out_valid && !out_ready;
            st_a = out_addr;
            st_d = out_data;
        end
    end

    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (n % 4 == 0) || (n % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_addr  = AW'(a);
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DP; i++) blk[i] = $urandom;
    endtask

    task automatic begin_run(input logic [1:0] m, input logic [DW-1:0] b, input int order,
                             input bit hold);
        proc_cyc = 0;
        beats    = 0;
        for (int i = 0; i < DP; i++) begin
            beat_t e;
            e.a = AW'(i);
            e.d = xform(m, b, blk[i]);
            exp_q.push_back(e);
        end
        start = 1'b1;
        mode  = m;
        bias  = b;
        step();
        start = hold;
        mode  = ~m;
        bias  = ~b;
        chk("load_state", state_out, 1);
        chk("load_in_ready", in_ready, 1);
        chk("load_busy", busy, 1);
        chk("load_done", done, 0);
        if (order == 1) begin
            wr(5, 32'hAAAA_AAAA);
            wr(64, 32'h0000_DEAD);
        end
        for (int j = 0; j < DP; j++) begin
            int i;
            i = (order == 1) ? DP - 1 - j : j;
            if (hold && j == 10) start = 1'b0;
            if (hold && j == 12) start = 1'b1;
            if (hold && j == 30) start = 1'b0;
            if (hold && j == 31) start = 1'b1;
            if (order == 1 && i == 0) begin
                repeat (3) step();
                chk("stay_in_load", state_out, 1);
            end
            wr(i, blk[i]);
        end
    endtask

    task automatic finish_run(input bit hold);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", seen, 1);
        chk("done_state", state_out, 4);
        chk("done_out_valid", out_valid, 0);
        chk("proc_cycles", proc_cyc, DP + 2);
        chk("beat_count", beats, DP);
        chk("queue_drained", exp_q.size(), 0);
        if (hold) begin
            repeat (3) @(negedge clk);
            chk("done_held", state_out, 4);
            @(posedge clk);
            #1 start = 1'b0;
        end
        seen = 1'b0;
        for (int n = 0; n < 6 && !seen; n++) begin
            @(negedge clk);
            seen = (state_out == 4'd0);
        end
        chk("back_to_idle", seen, 1);
        chk("idle_done_low", done, 0);
        exp_q.delete();
        step();
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        rst = 1'b0;
        step();
        chk("post_rst_state", state_out, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_addr", out_addr, 0);

        rdy_mode = 0;
        for (int i = 0; i < DP; i++) blk[i] = DW'(i) * 32'h0101_0101;
        begin_run(2'd1, '0, 0, 1'b0);
        finish_run(1'b0);

        rdy_mode = 1;
        fill_random();
        begin_run(2'd0, $urandom, 0, 1'b0);
        finish_run(1'b0);

        rdy_mode = 2;
        fill_random();
        blk[5] = 32'h0000_5555;
        begin_run(2'd1, '0, 1, 1'b0);
        finish_run(1'b0);

        rdy_mode = 0;
        fill_random();
        blk[0] = 32'hFFFF_FFF8;
        begin_run(2'd2, 32'h10, 0, 1'b0);
        finish_run(1'b0);

        fill_random();
        blk[0] = 32'h50;
        blk[1] = 32'h90;
        blk[2] = 32'h80;
        blk[3] = 32'h7F;
        begin_run(2'd3, 32'h80, 0, 1'b0);
        finish_run(1'b0);

        rdy_mode = 2;
        fill_random();
        begin_run(2'd3, $urandom, 0, 1'b1);
        finish_run(1'b1);

        rdy_mode = 1;
        fill_random();
        begin_run(2'd2, $urandom, 0, 1'b0);
        finish_run(1'b0);

        rdy_mode = 0;
        fill_random();
        begin_run(2'd1, '0, 0, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid && (out_addr == AW'(20));
        end
        chk("reach_addr20", seen, 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_state", state_out, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) step();
        chk("abort_stays_idle", state_out, 0);
        chk("abort_no_output", out_valid, 0);

        rdy_mode = 2;
        fill_random();
        begin_run(2'd3, $urandom, 0, 1'b0);
        finish_run(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
